// File: rtl/loby_pkg.sv
// Shared constants, types and helpers for the LoBy keyed sponge core.
package loby_pkg;

   // State, key and squeeze width. This is prime, so all ring indexing wraps mod SIZE.
   localparam int unsigned SIZE     = 257;
   // Absorb word width (rate). It must stay below SIZE.
   localparam int unsigned SIZE_DIN = 64;
   // Rounds unrolled combinationally per absorb/squeeze cycle.
   localparam int unsigned ROUNDS   = 4;

   // Ring offsets used by the theta-like mixing step.
   localparam int unsigned ROT_A = 12;
   localparam int unsigned ROT_B = 97;

   typedef logic [SIZE-1:0]     state_t;
   typedef logic [SIZE_DIN-1:0] word_t;

   // Ring rotation: bit i of the result is s[(i + n) mod SIZE].
   function automatic state_t rotr(input state_t s, input int unsigned n);
      state_t lo;
      state_t hi;
      lo = s >> n;
      hi = s << (SIZE - n);
      return lo | hi;
   endfunction

   // Round constant for round r; it is XORed into the low byte of the state.
   function automatic logic [7:0] rc(input int unsigned r);
      return 8'(r + 1);
   endfunction

endpackage

// File: rtl/loby_sponge_if.sv
// Command and data bundle between the LoBy wrapper (master) and the sponge core (slave).
interface loby_sponge_if;
   import loby_pkg::*;

   logic   init;
   logic   sqz;
   logic   din_valid;
   word_t  din;
   state_t key;
   state_t dout;

   modport master (
      output init,
      output sqz,
      output din_valid,
      output din,
      output key,
      input  dout
   );

   modport slave (
      input  init,
      input  sqz,
      input  din_valid,
      input  din,
      input  key,
      output dout
   );

endinterface

// File: rtl/loby_round.sv
// One combinational round of the LoBy permutation, specialised by its round index.
module loby_round
   import loby_pkg::*;
#(
   parameter int unsigned ROUND_IDX = 0
) (
   input  state_t s_in,
   output state_t s_out
);

   state_t mix;
   state_t chi;

   // Mix each bit with two distant ring neighbours, apply chi over the odd ring, then add the round constant.
   always_comb begin
      mix   = s_in ^ rotr(s_in, ROT_A) ^ rotr(s_in, ROT_B);
      chi   = mix ^ (~rotr(mix, 1) & rotr(mix, 2));
      s_out = {chi[SIZE-1:8], chi[7:0] ^ rc(ROUND_IDX)};
   end

endmodule

// File: rtl/loby_sponge.sv
// Keyed sponge core: init loads the key, absorb XORs a rate word into the low bits and permutes,
// squeeze permutes and publishes the new state on dout.
module loby_sponge
   import loby_pkg::*;
(
   input  logic         clk,
   input  logic         arstn,
   loby_sponge_if.slave bus
);

   state_t state_reg;
   state_t state_next;
   state_t dout_reg;
   state_t dout_next;
   state_t absorb_x;
   state_t perm_chain [ROUNDS+1];

   // Fold the rate word into the low bits of the state when an absorb is requested.
   always_comb begin
      absorb_x = state_reg;
      if (bus.din_valid) begin
         absorb_x = state_reg ^ {{(SIZE-SIZE_DIN){1'b0}}, bus.din};
      end
   end

   assign perm_chain[0] = absorb_x;

   generate
      for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_round
         loby_round #(
            .ROUND_IDX (gi)
         ) u_round (
            .s_in  (perm_chain[gi]),
            .s_out (perm_chain[gi+1])
         );
      end
   endgenerate

   // Next-state selection: init outranks absorb/squeeze; squeeze also captures the permuted state.
   always_comb begin
      state_next = state_reg;
      dout_next  = dout_reg;
      if (bus.init) begin
         state_next = bus.key;
      end else if (bus.din_valid || bus.sqz) begin
         state_next = perm_chain[ROUNDS];
         if (bus.sqz) begin
            dout_next = perm_chain[ROUNDS];
         end
      end
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!arstn) begin
         state_reg <= '0;
         dout_reg  <= '0;
      end else begin
         state_reg <= state_next;
         dout_reg  <= dout_next;
      end
   end

   assign bus.dout = dout_reg;

endmodule

// File: tb/tb_loby_sponge.sv
// Directed bench for loby_sponge; expected values come from a bit-level reference model of P.
module tb_loby_sponge;
   import loby_pkg::*;

   logic clk = 1'b0;
   logic arstn;
   int   tests_run = 0;
   int   tests_failed = 0;

   loby_sponge_if bus ();

   loby_sponge dut (
      .clk   (clk),
      .arstn (arstn),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference round written bit by bit with explicit modular indices.
   function automatic state_t round_model(input state_t s, input int r);
      state_t a;
      state_t b;
      logic [7:0] rcv;
      for (int i = 0; i < 257; i++) begin
         a[i] = s[i] ^ s[(i + 12) % 257] ^ s[(i + 97) % 257];
      end
      for (int i = 0; i < 257; i++) begin
         b[i] = a[i] ^ ((~a[(i + 1) % 257]) & a[(i + 2) % 257]);
      end
      rcv = 8'(r + 1);
      for (int k = 0; k < 8; k++) begin
         b[k] = b[k] ^ rcv[k];
      end
      return b;
   endfunction

   function automatic state_t p_model(input state_t s);
      state_t t;
      t = s;
      for (int r = 0; r < 4; r++) begin
         t = round_model(t, r);
      end
      return t;
   endfunction

   function automatic state_t ext(input logic [63:0] w);
      return {193'b0, w};
   endfunction

   task automatic check_eq(input string tag, input state_t got, input state_t exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s", tag);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic i_init, input logic i_sqz, input logic i_dv,
                        input logic [63:0] i_din, input state_t i_key);
      bus.init      = i_init;
      bus.sqz       = i_sqz;
      bus.din_valid = i_dv;
      bus.din       = i_din;
      bus.key       = i_key;
      cyc();
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, '0);
   endtask

   // Directed vector table: key, d0..d3.
   state_t      vk [3];
   logic [63:0] vd [3][4];

   initial begin
      state_t ones;
      state_t s1, s2, s3, s4;
      state_t k2, k3, k4;
      state_t held;

      vk[0] = {1'b1, 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0};
      vk[1] = '0;
      vk[2] = {1'b0, 256'hA5A5_A5A5_5A5A_5A5A_FFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0_0000_0000_0000_0001};
      vd[0][0] = 64'h0000_0000_0000_0001; vd[0][1] = 64'h8000_0000_0000_0000;
      vd[0][2] = 64'hFFFF_FFFF_FFFF_FFFF; vd[0][3] = 64'h0123_4567_89AB_CDEF;
      vd[1][0] = 64'h0;                   vd[1][1] = 64'h0;
      vd[1][2] = 64'h0;                   vd[1][3] = 64'h0;
      vd[2][0] = 64'hCAFE_BABE_DEAD_BEEF; vd[2][1] = 64'h1111_2222_3333_4444;
      vd[2][2] = 64'h5555_AAAA_5555_AAAA; vd[2][3] = 64'hFEDC_BA98_7654_3210;

      ones = '1;
      k2   = {1'b1, 256'h1};
      k3   = {1'b0, 256'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000_0000_0000_0000_0000_0000_0000_0000_0000};
      k4   = ones;

      // Reset wins over init.
      arstn = 1'b0;
      apply(1'b1, 1'b0, 1'b0, 64'h0, ones);
      apply(1'b1, 1'b0, 1'b0, 64'h0, ones);
      check_eq("reset_dout", bus.dout, '0);
      check_eq("reset_state", dut.state_reg, '0);

      // Init with zero key, then squeeze.
      arstn = 1'b1;
      apply(1'b1, 1'b0, 1'b0, 64'h0, '0);
      apply(1'b0, 1'b1, 1'b0, 64'h0, '0);
      check_eq("init_sqz_p0", bus.dout, p_model('0));
      check_eq("init_sqz_nonzero", {256'b0, (bus.dout != '0)}, {256'b0, 1'b1});

      // Vector sequence.
      for (int e = 0; e < 3; e++) begin
         s1 = p_model(vk[e] ^ ext(vd[e][0]));
         s2 = p_model(s1 ^ ext(vd[e][1]));
         s3 = p_model(s2 ^ ext(vd[e][2]));
         s4 = p_model(s3 ^ ext(vd[e][3]));
         apply(1'b1, 1'b0, 1'b0, 64'h0, vk[e]);
         apply(1'b0, 1'b0, 1'b1, vd[e][0], '0);
         idle();
         apply(1'b0, 1'b0, 1'b1, vd[e][1], '0);
         idle();
         apply(1'b0, 1'b1, 1'b1, vd[e][2], '0);
         check_eq($sformatf("vec%0d_sqz1", e), bus.dout, s3);
         idle();
         check_eq($sformatf("vec%0d_idle", e), bus.dout, s3);
         apply(1'b0, 1'b1, 1'b1, vd[e][3], '0);
         check_eq($sformatf("vec%0d_final", e), bus.dout, s4);
      end

      // Hold through idle cycles and an init (with sqz/din_valid also raised, which init overrides).
      held = bus.dout;
      for (int i = 0; i < 5; i++) begin
         idle();
         check_eq($sformatf("hold_idle%0d", i), bus.dout, held);
      end
      apply(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, k2);
      check_eq("hold_init_dout", bus.dout, held);
      check_eq("hold_init_state", dut.state_reg, k2);
      apply(1'b0, 1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, '0);
      check_eq("hold_new_key_sqz", bus.dout, p_model(k2));

      // Absorb-only leaves dout alone; the following squeeze reflects two permutations.
      held = bus.dout;
      apply(1'b1, 1'b0, 1'b0, 64'h0, k3);
      apply(1'b0, 1'b0, 1'b1, 64'h1, '0);
      check_eq("absorb_only_dout", bus.dout, held);
      apply(1'b0, 1'b1, 1'b0, 64'h0, '0);
      check_eq("absorb_then_sqz", bus.dout, p_model(p_model(k3 ^ ext(64'h1))));

      // Reset between the two absorbs.
      apply(1'b1, 1'b0, 1'b0, 64'h0, k4);
      apply(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00FF, '0);
      arstn = 1'b0;
      apply(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_FF00, '0);
      arstn = 1'b1;
      check_eq("midrst_dout", bus.dout, '0);
      check_eq("midrst_state", dut.state_reg, '0);
      apply(1'b0, 1'b1, 1'b0, 64'h0, '0);
      check_eq("midrst_sqz_p0", bus.dout, p_model('0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/loby_sponge.md
Name: loby_sponge

Overview:
- Keyed sponge core with a 257-bit state and a 64-bit rate.
- Keys the state from a 257-bit key, absorbs 64-bit input words, and squeezes the full 257-bit state as output.
- Sits below the LoBy wrapper; all datapath is single-clock, one operation per cycle.

Parameters:
- SIZE, 257, state/key/dout width (prime; ring indexing is mod SIZE)
- SIZE_DIN, 64, absorb word width (rate); must be < SIZE
- ROUNDS, 4, permutation rounds unrolled combinationally per absorb/squeeze cycle

Ports:
- clk  in  1  rising-edge clock
- arstn  in  1  reset, active-low, synchronous
- init  in  1  load key into state
- sqz  in  1  squeeze request; dout updated this cycle
- din  in  SIZE_DIN  absorb word
- din_valid  in  1  din is absorbed this cycle
- key  in  SIZE  key loaded on init
- dout  out  SIZE  registered squeeze output

Interface (already decided): one clock; reset is synchronous and active-low (clock clk, reset arstn).

Behaviour:
- Registers: state[SIZE-1:0], dout[SIZE-1:0]. No other state, no FSM.
- Reset: on a rising edge with arstn=0, state<=0 and dout<=0. Reset overrides all other inputs, including mid-sequence.
- Priority per edge (arstn=1): init > (din_valid | sqz) > idle.
- init=1: state<=key. dout holds. din_valid and sqz are ignored that cycle.
- din_valid | sqz (init=0):
  - x = state ^ {(SIZE-SIZE_DIN)'b0, din} when din_valid=1, else x = state.
  - state <= P(x).
  - When sqz=1, also dout <= P(x), the same new state value.
- Idle (none asserted): state and dout hold.
- Latency: absorb and squeeze take 1 cycle each. dout is valid after the edge that sampled sqz=1 and holds until the next squeeze, or until reset.
- Permutation P = ROUNDS applications of round function f_r, r = 0..ROUNDS-1. All indices are mod SIZE:
  - a[i] = s[i] ^ s[i+12] ^ s[i+97]
  - b[i] = a[i] ^ (~a[i+1] & a[i+2]) (chi over an odd ring)
  - b[7:0] ^= RC[r], where RC[r] = r+1 (8-bit)
  - output b
- din bits beyond the rate are never touched; din is don't-care when din_valid=0.
- din_valid=1 together with sqz=1 is legal: absorb and squeeze happen in the same cycle.
- Output word ordering: bit 0 of din and key maps to state bit 0. Test vectors from the golden model are bit-reversed (MSB-first text) before being applied.

Decomposition:
- Package loby_pkg:
  - constants SIZE, SIZE_DIN, ROUNDS
  - rotation offsets ROT_A=12, ROT_B=97
  - round-constant function RC(r)
  - typedef state_t (logic [SIZE-1:0])
- Sub-module loby_round: purely combinational single round, parameterised by round index r.
- Top instantiates ROUNDS copies in a generate chain.

Test Plan:
- Reset values: hold arstn=0 for 2 cycles with init=1, key=all-ones -> dout=0, state=0; reset wins over init.
- Init then squeeze: arstn=1; init key=0; next cycle sqz=1, din_valid=0 -> dout = P(0). Compare against the golden model; the result must be nonzero because RC is nonzero.
- Vector sequence, repeated per file entry:
  - init(key), absorb(d0), idle, absorb(d1), idle, squeeze with din_valid (d2), idle, squeeze with din_valid (d3)
  - -> final dout equals the file expected value (bit-reversed) for every entry; no mismatch allowed.
- Hold: after a squeeze, 5 idle cycles, then init with a new key -> dout unchanged throughout; next squeeze reflects only the new key.
- Absorb-only: din_valid=1, sqz=0 with din=64'h1 -> dout unchanged. A following sqz (din_valid=0) gives P(P(key^1)), matching the model.
- Reset mid-operation: deassert arstn for one cycle between the two absorbs -> dout=0 and state=0. A subsequent squeeze without init gives P(0).
